lsu: RTL

Load/store unit between the CPU execute stage and the word-addressed data memory. Converts byte-addressed RISC-V loads and stores into 32-bit word accesses, because the data memory has no byte enables. Sub-word stores use a read-modify-write sequence. Loads are extracted and sign/zero-extended, and misaligned or illegal requests are flagged without touching memory.

---
 rtl/lsu.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: byte-addressed RISC-V load/store unit in front of a word-only data memory.
// Sub-word stores use read-modify-write; misaligned or illegal requests return an error.
`default_nettype none

module lsu #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_is_load,
    output logic        mem_is_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store_data,
    input  logic [31:0] mem_load_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH+1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [31:0]           wdata_q;
    logic                  load_q;

    logic                  ld_legal, st_legal, align_ok, req_err;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_ext, merged;

    // Address bits above the memory size are deliberately dropped (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    always_comb begin
        ld_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        st_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        case (req_funct3[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        if (req_is_load && !req_is_store)
            req_err = !(ld_legal && align_ok);
        else if (req_is_store && !req_is_load)
            req_err = !(st_legal && align_ok);
        else
            req_err = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                      state_nxt = RESP;
                    else if (req_is_load)             state_nxt = RD;
                    else if (req_funct3[1:0] == 2'b10) state_nxt = WR;
                    else                              state_nxt = RD;
                end
            end
            RD:      state_nxt = load_q ? IDLE : WR;
            WR:      state_nxt = IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Little-endian lane extraction and lane merge for the read-modify-write.
    always_comb begin
        lane_byte = mem_load_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h0, lane_byte};
            3'b101:  load_ext = {16'h0, lane_half};
            default: load_ext = mem_load_data;
        endcase
        merged = mem_load_data;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q         <= '0;
            funct3_q       <= '0;
            wdata_q        <= '0;
            load_q         <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_store_data <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q         <= req_addr[ADDR_WIDTH+1:0];
                        funct3_q       <= req_funct3;
                        wdata_q        <= req_wdata;
                        load_q         <= req_is_load;
                        // Full-word stores go straight to WR with the raw data.
                        mem_store_data <= req_wdata;
                    end
                end
                RD: begin
                    if (load_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                    end else begin
                        mem_store_data <= merged;
                    end
                end
                WR:   resp_valid <= 1'b1;
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign mem_is_load  = (state == RD);
    assign mem_is_store = (state == WR);
    assign mem_addr     = {{(32-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};

endmodule

`default_nettype wire
